// File: rtl/div_hazard_ctrl.sv
// Divider hazard/sequencing control: tracks the in-flight divide's rd, stalls dependent ID ops, owns the WB port for one cycle.
// Stall/flush/jump outputs are combinational (zero latency); only state, pend_rd, cnt and div_err are registered.
module div_hazard_ctrl #(
  parameter int DIV_TIMEOUT = 64,
  parameter int CNT_W       = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_reg1_raddr_i,
  input  logic [4:0]  id_reg2_raddr_i,
  input  logic        id_reg_we_i,
  input  logic [4:0]  id_reg_waddr_i,
  input  logic        div_start_i,
  input  logic [4:0]  div_waddr_i,
  input  logic        div_done_i,
  input  logic        ex_jump_flag_i,
  input  logic [31:0] ex_jump_addr_i,
  output logic        hold_pc_o,
  output logic        hold_if_id_o,
  output logic        bubble_id_ex_o,
  output logic        hold_id_ex_o,
  output logic        ex_wb_block_o,
  output logic        div_wb_grant_o,
  output logic        div_busy_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic        flush_o,
  output logic        div_err_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_WB   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [4:0]       pend_rd_q, pend_rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_err_q, div_err_d;

  logic in_busy;
  logic in_wb;
  logic raw_hit;
  logic waw_hit;
  logic hazard_hit;
  logic struct_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pend_rd_q <= '0;
      cnt_q     <= '0;
      div_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_rd_q <= pend_rd_d;
      cnt_q     <= cnt_d;
      div_err_q <= div_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_rd_d = pend_rd_q;
    cnt_d     = cnt_q;
    div_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (div_start_i) begin
          state_d   = DIV_BUSY;
          pend_rd_d = div_waddr_i;
          cnt_d     = '0;
        end
      end
      DIV_BUSY: begin
        // A done on the last allowed cycle still wins over the timeout.
        if (div_done_i) begin
          state_d = DIV_WB;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          pend_rd_d = '0;
          cnt_d     = '0;
          div_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DIV_WB: begin
        state_d   = IDLE;
        pend_rd_d = '0;
      end
      default: begin
        state_d   = IDLE;
        pend_rd_d = '0;
        cnt_d     = '0;
      end
    endcase
  end

  assign in_busy    = (state_q == DIV_BUSY);
  assign in_wb      = (state_q == DIV_WB);
  assign raw_hit    = (id_reg1_raddr_i == pend_rd_q) || (id_reg2_raddr_i == pend_rd_q);
  assign waw_hit    = id_reg_we_i && (id_reg_waddr_i == pend_rd_q);
  assign hazard_hit = in_busy && (pend_rd_q != 5'd0) && (raw_hit || waw_hit);
  assign struct_hit = in_busy && div_start_i;

  // EX is frozen during writeback, so a jump there is re-presented next cycle.
  always_comb begin
    hold_pc_o      = 1'b0;
    hold_if_id_o   = 1'b0;
    bubble_id_ex_o = 1'b0;
    hold_id_ex_o   = 1'b0;
    ex_wb_block_o  = 1'b0;
    div_wb_grant_o = 1'b0;
    jump_flag_o    = 1'b0;
    jump_addr_o    = '0;
    flush_o        = 1'b0;
    if (in_wb) begin
      hold_pc_o      = 1'b1;
      hold_if_id_o   = 1'b1;
      hold_id_ex_o   = 1'b1;
      ex_wb_block_o  = 1'b1;
      div_wb_grant_o = 1'b1;
    end else if (ex_jump_flag_i) begin
      jump_flag_o = 1'b1;
      jump_addr_o = ex_jump_addr_i;
      flush_o     = 1'b1;
    end else if (struct_hit) begin
      hold_pc_o    = 1'b1;
      hold_if_id_o = 1'b1;
      hold_id_ex_o = 1'b1;
    end else if (hazard_hit) begin
      hold_pc_o      = 1'b1;
      hold_if_id_o   = 1'b1;
      bubble_id_ex_o = 1'b1;
    end
  end

  assign div_busy_o = (state_q != IDLE);
  assign div_err_o  = div_err_q;

endmodule

// File: tb/tb_div_hazard_ctrl.sv
// Bench for div_hazard_ctrl: directed scenarios plus random traffic, every cycle checked against a transaction-level model.
module tb_div_hazard_ctrl;
  localparam int TO = 12;
  localparam int CW = 5;

  // obs_ctl bit positions
  localparam int B_HPC = 9, B_HIF = 8, B_BUB = 7, B_HEX = 6, B_BLK = 5;
  localparam int B_GNT = 4, B_BSY = 3, B_JMP = 2, B_FLS = 1, B_ERR = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_reg1_raddr_i, id_reg2_raddr_i, id_reg_waddr_i, div_waddr_i;
  logic        id_reg_we_i, div_start_i, div_done_i, ex_jump_flag_i;
  logic [31:0] ex_jump_addr_i;
  logic        hold_pc_o, hold_if_id_o, bubble_id_ex_o, hold_id_ex_o, ex_wb_block_o;
  logic        div_wb_grant_o, div_busy_o, jump_flag_o, flush_o, div_err_o;
  logic [31:0] jump_addr_o;

  div_hazard_ctrl #(.DIV_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_reg1_raddr_i(id_reg1_raddr_i), .id_reg2_raddr_i(id_reg2_raddr_i),
    .id_reg_we_i(id_reg_we_i), .id_reg_waddr_i(id_reg_waddr_i),
    .div_start_i(div_start_i), .div_waddr_i(div_waddr_i), .div_done_i(div_done_i),
    .ex_jump_flag_i(ex_jump_flag_i), .ex_jump_addr_i(ex_jump_addr_i),
    .hold_pc_o(hold_pc_o), .hold_if_id_o(hold_if_id_o), .bubble_id_ex_o(bubble_id_ex_o),
    .hold_id_ex_o(hold_id_ex_o), .ex_wb_block_o(ex_wb_block_o), .div_wb_grant_o(div_wb_grant_o),
    .div_busy_o(div_busy_o), .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o),
    .flush_o(flush_o), .div_err_o(div_err_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one outstanding divide tracked as a transaction.
  bit         m_pending;   // result not yet returned
  bit         m_wb;        // result returning this cycle
  bit         m_err;
  int         m_age;       // busy cycles already spent
  logic [4:0] m_rd;

  logic [9:0]  obs_ctl;
  logic [31:0] obs_addr;

  function automatic void model_out(output logic [9:0] ctl, output logic [31:0] addr);
    bit dep;
    ctl  = '0;
    addr = '0;
    ctl[B_BSY] = m_pending || m_wb;
    ctl[B_ERR] = m_err;
    dep = m_pending && (m_rd != 0) &&
          (id_reg1_raddr_i == m_rd || id_reg2_raddr_i == m_rd ||
           (id_reg_we_i && id_reg_waddr_i == m_rd));
    if (m_wb) begin
      ctl[B_HPC] = 1; ctl[B_HIF] = 1; ctl[B_HEX] = 1; ctl[B_BLK] = 1; ctl[B_GNT] = 1;
    end else if (ex_jump_flag_i) begin
      ctl[B_JMP] = 1; ctl[B_FLS] = 1; addr = ex_jump_addr_i;
    end else if (m_pending && div_start_i) begin
      ctl[B_HPC] = 1; ctl[B_HIF] = 1; ctl[B_HEX] = 1;
    end else if (dep) begin
      ctl[B_HPC] = 1; ctl[B_HIF] = 1; ctl[B_BUB] = 1;
    end
  endfunction

  function automatic void model_update();
    if (rst) begin
      m_pending = 0; m_wb = 0; m_err = 0; m_age = 0; m_rd = 0;
    end else if (m_wb) begin
      m_wb = 0; m_err = 0;
    end else if (m_pending) begin
      m_err = 0;
      if (div_done_i) begin
        m_pending = 0; m_wb = 1;
      end else if (m_age + 1 >= TO) begin
        m_pending = 0; m_err = 1;
      end else begin
        m_age++;
      end
    end else begin
      m_err = 0;
      if (div_start_i) begin
        m_pending = 1; m_age = 0; m_rd = div_waddr_i;
      end
    end
  endfunction

  task automatic step();
    logic [9:0]  e_ctl;
    logic [31:0] e_addr;
    @(negedge clk);
    model_out(e_ctl, e_addr);
    obs_ctl  = {hold_pc_o, hold_if_id_o, bubble_id_ex_o, hold_id_ex_o, ex_wb_block_o,
                div_wb_grant_o, div_busy_o, jump_flag_o, flush_o, div_err_o};
    obs_addr = jump_addr_o;
    chk("ctl", {54'd0, obs_ctl}, {54'd0, e_ctl});
    chk("addr", {32'd0, obs_addr}, {32'd0, e_addr});
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic quiet();
    rst = 0; id_reg1_raddr_i = 0; id_reg2_raddr_i = 0; id_reg_we_i = 0; id_reg_waddr_i = 0;
    div_start_i = 0; div_waddr_i = 0; div_done_i = 0; ex_jump_flag_i = 0; ex_jump_addr_i = 0;
  endtask

  function automatic bit stalled();
    return obs_ctl[B_HPC] && obs_ctl[B_HIF] && obs_ctl[B_BUB];
  endfunction

  initial begin
    int n_busy, n_stall, n_gnt, n_err;
    quiet();
    m_pending = 0; m_wb = 0; m_err = 0; m_age = 0; m_rd = 0;
    rst = 1; step(); step(); rst = 0;
    step();
    chk("reset_ctl", {54'd0, obs_ctl}, 64'd0);

    // DIV x5, done 10 cycles later, ID reading x5 the whole time
    div_start_i = 1; div_waddr_i = 5; id_reg1_raddr_i = 5; step();
    div_start_i = 0; n_busy = 0; n_stall = 0; n_gnt = 0;
    for (int i = 0; i < 10; i++) begin
      div_done_i = (i == 9);
      step();
      n_busy += obs_ctl[B_BSY]; n_stall += stalled(); n_gnt += obs_ctl[B_GNT];
    end
    div_done_i = 0; step();
    n_busy += obs_ctl[B_BSY]; n_gnt += obs_ctl[B_GNT];
    chk("wb_cycle", {54'd0, obs_ctl}, 64'b11_0111_1000);
    chk("raw_stall_cnt", n_stall, 10);
    step();
    n_busy += obs_ctl[B_BSY];
    chk("busy_cnt", n_busy, 11);
    chk("grant_cnt", n_gnt, 1);
    chk("raw_release", {54'd0, obs_ctl}, 64'd0);

    // WAW on x5
    quiet(); div_start_i = 1; div_waddr_i = 5; step();
    quiet(); id_reg_we_i = 1; id_reg_waddr_i = 5; n_stall = 0;
    for (int i = 0; i < 3; i++) begin div_done_i = (i == 2); step(); n_stall += stalled(); end
    div_done_i = 0; step(); step();
    chk("waw_stall_cnt", n_stall, 3);
    chk("waw_release", obs_ctl[B_HPC], 0);

    // No false stall: x5 pending, ID uses x6/x0; then divide to x0 with ID on x0
    quiet(); div_start_i = 1; div_waddr_i = 5; step();
    quiet(); id_reg1_raddr_i = 6; id_reg_we_i = 1; id_reg_waddr_i = 6; n_stall = 0;
    for (int i = 0; i < 4; i++) begin div_done_i = (i == 3); step(); n_stall += stalled(); end
    quiet(); step(); step();
    div_start_i = 1; div_waddr_i = 0; step();
    quiet(); id_reg_we_i = 1; n_gnt = 0;
    for (int i = 0; i < 5; i++) begin
      div_done_i = (i == 3); step(); n_stall += stalled(); n_gnt += obs_ctl[B_GNT];
    end
    chk("no_false_stall", n_stall, 0);
    chk("x0_grant", n_gnt, 1);

    // Jump during busy with a RAW hit, then jump coincident with writeback
    quiet(); div_start_i = 1; div_waddr_i = 5; id_reg1_raddr_i = 5; step();
    div_start_i = 0; step();
    chk("pre_jump_stall", stalled(), 1);
    ex_jump_flag_i = 1; ex_jump_addr_i = 32'h100; step();
    chk("jmp_flag", obs_ctl[B_JMP], 1);
    chk("jmp_addr", obs_addr, 32'h100);
    chk("jmp_flush", obs_ctl[B_FLS], 1);
    chk("jmp_hold_pc", obs_ctl[B_HPC], 0);
    ex_jump_flag_i = 0; ex_jump_addr_i = 0; step();
    chk("jmp_still_busy", obs_ctl[B_BSY], 1);
    div_done_i = 1; step();
    div_done_i = 0; ex_jump_flag_i = 1; ex_jump_addr_i = 32'h200; step();
    chk("wb_jmp_masked", obs_ctl[B_JMP], 0);
    step();
    chk("wb_jmp_after", obs_addr, 32'h200);

    // Structural: second divide in EX while busy
    quiet(); div_start_i = 1; div_waddr_i = 4; step();
    div_waddr_i = 9; step();
    chk("struct_hold", {61'd0, obs_ctl[B_HPC], obs_ctl[B_HEX], obs_ctl[B_BUB]}, 64'b110);
    div_done_i = 1; step();
    div_done_i = 0; step(); step();
    quiet(); div_done_i = 1; step(); div_done_i = 0; step(); step();

    // Timeout, ID reading the pending register
    quiet(); div_start_i = 1; div_waddr_i = 3; step();
    quiet(); id_reg2_raddr_i = 3; n_busy = 0; n_err = 0;
    for (int i = 0; i < TO + 3; i++) begin
      step();
      n_busy += obs_ctl[B_BSY];
      if (obs_ctl[B_ERR]) begin
        n_err++;
        chk("err_in_idle", {54'd0, obs_ctl}, 64'd1);
      end
    end
    chk("timeout_busy", n_busy, TO);
    chk("err_pulses", n_err, 1);

    // Reset mid-divide discards the writeback
    quiet(); div_start_i = 1; div_waddr_i = 7; step();
    quiet(); step(); step();
    rst = 1; step(); rst = 0;
    n_gnt = 0; n_busy = 0;
    for (int i = 0; i < 4; i++) begin div_done_i = 1; step(); n_gnt += obs_ctl[B_GNT]; n_busy += obs_ctl[B_BSY]; end
    chk("rst_no_grant", n_gnt, 0);
    chk("rst_idle", n_busy, 0);

    // Random traffic
    quiet();
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(0, 199) == 0);
      id_reg1_raddr_i = 5'($urandom_range(0, 7));
      id_reg2_raddr_i = 5'($urandom_range(0, 7));
      id_reg_we_i     = $urandom_range(0, 1) == 1;
      id_reg_waddr_i  = 5'($urandom_range(0, 7));
      div_start_i     = ($urandom_range(0, 99) < 25);
      div_waddr_i     = 5'($urandom_range(0, 7));
      div_done_i      = ($urandom_range(0, 99) < 15);
      ex_jump_flag_i  = ($urandom_range(0, 99) < 10);
      ex_jump_addr_i  = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
